// File: rtl/turn_sequencer.sv
// Multi-player turn controller feeding snakes_ladders: takes one roll per turn, bounds the move,
// queries the board for the adjusted square, commits it, rotates turns and latches the winner.
module turn_sequencer #(
  parameter int NUM_PLAYERS = 4,
  parameter int WIN_POS     = 100,
  parameter int MAX_SIXES   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll_req,
  input  logic [2:0] dice_value,
  output logic [6:0] sl_query_pos,
  input  logic [6:0] sl_adjusted_pos,
  input  logic [1:0] rd_player,
  output logic [6:0] rd_pos,
  output logic [1:0] cur_player,
  output logic       busy,
  output logic       move_done,
  output logic       bad_roll,
  output logic       win,
  output logic [1:0] winner
);

  localparam int SIX_W = $clog2(MAX_SIXES + 1);

  typedef enum logic [1:0] {IDLE, CALC, LOOKUP, OVER} state_t;

  state_t             state_q;
  logic [2:0]         die_q;
  logic [6:0]         pos_q [4];
  logic [1:0]         cur_q;
  logic [SIX_W-1:0]   six_q;
  logic               bad_q;
  logic               forfeit_q;
  logic [6:0]         query_q;
  logic               busy_q;
  logic               done_q;
  logic               badp_q;
  logic               win_q;
  logic [1:0]         winner_q;

  logic [6:0]         cur_pos_d;
  logic [7:0]         sum_d;
  logic               bad_d;
  logic               forfeit_d;
  logic [6:0]         cand_d;
  logic [1:0]         next_player_d;

  // Refused moves (bad die, forfeit, overshoot) leave the player on its current square.
  function automatic logic [6:0] bounded_move(input logic [6:0] pos, input logic [7:0] sum,
                                              input logic refuse);
    if (refuse || (sum > 8'(WIN_POS)))
      return pos;
    return sum[6:0];
  endfunction

  always_comb begin
    cur_pos_d     = pos_q[cur_q];
    sum_d         = {1'b0, cur_pos_d} + {5'b0, die_q};
    bad_d         = (die_q == 3'd0) || (die_q == 3'd7);
    forfeit_d     = !bad_d && (die_q == 3'd6) && (six_q == SIX_W'(MAX_SIXES - 1));
    cand_d        = bounded_move(cur_pos_d, sum_d, bad_d || forfeit_d);
    next_player_d = (cur_q == 2'(NUM_PLAYERS - 1)) ? 2'd0 : cur_q + 2'd1;
    rd_pos        = (int'(rd_player) < NUM_PLAYERS) ? pos_q[rd_player] : 7'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      die_q     <= '0;
      for (int i = 0; i < 4; i++) pos_q[i] <= '0;
      cur_q     <= '0;
      six_q     <= '0;
      bad_q     <= 1'b0;
      forfeit_q <= 1'b0;
      query_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      badp_q    <= 1'b0;
      win_q     <= 1'b0;
      winner_q  <= '0;
    end else begin
      done_q <= 1'b0;
      badp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (roll_req) begin
            die_q   <= dice_value;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          query_q   <= cand_d;
          bad_q     <= bad_d;
          forfeit_q <= forfeit_d;
          state_q   <= LOOKUP;
        end
        LOOKUP: begin
          pos_q[cur_q] <= sl_adjusted_pos;
          done_q       <= 1'b1;
          badp_q       <= bad_q;
          busy_q       <= 1'b0;
          if (sl_adjusted_pos == 7'(WIN_POS)) begin
            win_q    <= 1'b1;
            winner_q <= cur_q;
            state_q  <= OVER;
          end else if ((die_q == 3'd6) && !forfeit_q) begin
            six_q   <= six_q + SIX_W'(1);
            state_q <= IDLE;
          end else begin
            six_q   <= '0;
            cur_q   <= next_player_d;
            state_q <= IDLE;
          end
        end
        OVER:    state_q <= OVER;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sl_query_pos = query_q;
  assign cur_player   = cur_q;
  assign busy         = busy_q;
  assign move_done    = done_q;
  assign bad_roll     = badp_q;
  assign win          = win_q;
  assign winner       = winner_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer: a 4-player instance plays a scripted game against a small
// board map, and a 2-player instance covers turn wrap and the out-of-range read port.
module tb_turn_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       roll1, roll2;
  logic [2:0] dice1, dice2;
  logic [6:0] q1, q2, adj1, adj2, rdpos1, rdpos2;
  logic [1:0] rdp1, rdp2, cur1, cur2, wnr1, wnr2;
  logic       busy1, busy2, md1, md2, br1, br2, win1, win2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] sl_map(input logic [6:0] p);
    case (p)
      7'd9:    return 7'd31;
      7'd51:   return 7'd90;
      default: return p;
    endcase
  endfunction

  assign adj1 = sl_map(q1);
  assign adj2 = sl_map(q2);

  turn_sequencer u_dut (
    .clk(clk), .reset(reset), .roll_req(roll1), .dice_value(dice1),
    .sl_query_pos(q1), .sl_adjusted_pos(adj1), .rd_player(rdp1), .rd_pos(rdpos1),
    .cur_player(cur1), .busy(busy1), .move_done(md1), .bad_roll(br1),
    .win(win1), .winner(wnr1)
  );

  turn_sequencer #(.NUM_PLAYERS(2)) u_dut2 (
    .clk(clk), .reset(reset), .roll_req(roll2), .dice_value(dice2),
    .sl_query_pos(q2), .sl_adjusted_pos(adj2), .rd_player(rdp2), .rd_pos(rdpos2),
    .cur_player(cur2), .busy(busy2), .move_done(md2), .bad_roll(br2),
    .win(win2), .winner(wnr2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic read_pos(input int which, input int player, output int p);
    if (which == 0) rdp1 = 2'(player);
    else            rdp2 = 2'(player);
    #1;
    p = (which == 0) ? int'(rdpos1) : int'(rdpos2);
  endtask

  // Request at edge N, sample the query after N+1 and move_done/bad_roll after N+2.
  task automatic roll(input int which, input logic [2:0] d, input bit extra,
                      output int q, output int md, output int br);
    @(negedge clk);
    if (which == 0) begin roll1 = 1'b1; dice1 = d; end
    else            begin roll2 = 1'b1; dice2 = d; end
    @(negedge clk);
    roll1 = 1'b0;
    roll2 = 1'b0;
    chk("busy_calc", (which == 0) ? int'(busy1) : int'(busy2), 1);
    if (extra) roll1 = 1'b1;
    @(negedge clk);
    roll1 = 1'b0;
    q = (which == 0) ? int'(q1) : int'(q2);
    @(negedge clk);
    md = (which == 0) ? int'(md1) : int'(md2);
    br = (which == 0) ? int'(br1) : int'(br2);
  endtask

  task automatic turn(input int which, input logic [2:0] d, input bit extra, input int eq,
                      input int ebr, input int ecur, input int epos, input string tag);
    int q, md, br, mover, p;
    mover = (which == 0) ? int'(cur1) : int'(cur2);
    roll(which, d, extra, q, md, br);
    chk({tag, ".query"}, q, eq);
    chk({tag, ".done"}, md, 1);
    chk({tag, ".bad"}, br, ebr);
    chk({tag, ".cur"}, (which == 0) ? int'(cur1) : int'(cur2), ecur);
    read_pos(which, mover, p);
    chk({tag, ".pos"}, p, epos);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p, md_seen;
    reset = 1'b1;
    roll1 = 1'b0; roll2 = 1'b0;
    dice1 = 3'd0; dice2 = 3'd0;
    rdp1 = 2'd0;  rdp2 = 2'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst.cur", int'(cur1), 0);
    chk("rst.busy", int'(busy1), 0);
    chk("rst.done", int'(md1), 0);
    chk("rst.bad", int'(br1), 0);
    chk("rst.win", int'(win1), 0);
    chk("rst.winner", int'(wnr1), 0);
    chk("rst.query", int'(q1), 0);
    chk("rst.win2", int'(win2), 0);
    chk("rst.winner2", int'(wnr2), 0);
    read_pos(0, 0, p);
    chk("rst.pos0", p, 0);

    // First round; player 3 wraps the turn back to 0
    turn(0, 3'd3, 1'b0,  3, 0, 1,  3, "t1");
    turn(0, 3'd1, 1'b0,  1, 0, 2,  1, "p1a");
    turn(0, 3'd1, 1'b0,  1, 0, 3,  1, "p2a");
    turn(0, 3'd1, 1'b0,  1, 0, 0,  1, "p3a");
    // Six onto the 9->31 ladder keeps the turn
    turn(0, 3'd6, 1'b0,  9, 0, 0, 31, "six_ladder");
    turn(0, 3'd2, 1'b0, 33, 0, 1, 33, "after_six");
    // Illegal dice: no move, turn passes, bad_roll with move_done
    turn(0, 3'd0, 1'b0,  1, 1, 2,  1, "bad0");
    turn(0, 3'd7, 1'b0,  1, 1, 3,  1, "bad7");
    turn(0, 3'd1, 1'b0,  2, 0, 0,  2, "p3b");
    // Three sixes: third is forfeited, with a stray request while busy
    turn(0, 3'd6, 1'b0, 39, 0, 0, 39, "six1");
    turn(0, 3'd6, 1'b0, 45, 0, 0, 45, "six2");
    turn(0, 3'd6, 1'b1, 45, 0, 1, 45, "six3_forfeit");
    @(negedge clk);
    chk("ignored_req.done", int'(md1), 0);
    chk("ignored_req.busy", int'(busy1), 0);
    chk("ignored_req.cur", int'(cur1), 1);
    turn(0, 3'd1, 1'b0,  2, 0, 2,  2, "p1c");
    turn(0, 3'd1, 1'b0,  2, 0, 3,  2, "p2c");
    turn(0, 3'd1, 1'b0,  3, 0, 0,  3, "p3c");
    turn(0, 3'd6, 1'b0, 51, 0, 0, 90, "six_ladder2");
    turn(0, 3'd5, 1'b0, 95, 0, 1, 95, "to95");
    turn(0, 3'd1, 1'b0,  3, 0, 2,  3, "p1d");
    turn(0, 3'd1, 1'b0,  3, 0, 3,  3, "p2d");
    turn(0, 3'd1, 1'b0,  4, 0, 0,  4, "p3d");
    turn(0, 3'd2, 1'b0, 97, 0, 1, 97, "to97");
    turn(0, 3'd1, 1'b0,  4, 0, 2,  4, "p1e");
    turn(0, 3'd1, 1'b0,  4, 0, 3,  4, "p2e");
    turn(0, 3'd1, 1'b0,  5, 0, 0,  5, "p3e");
    // Overshoot: stays put; plain die passes turn, a six keeps it
    turn(0, 3'd5, 1'b0, 97, 0, 1, 97, "overshoot");
    turn(0, 3'd1, 1'b0,  5, 0, 2,  5, "p1f");
    turn(0, 3'd1, 1'b0,  5, 0, 3,  5, "p2f");
    turn(0, 3'd1, 1'b0,  6, 0, 0,  6, "p3f");
    turn(0, 3'd6, 1'b0, 97, 0, 0, 97, "overshoot6");
    // Exact landing wins
    turn(0, 3'd3, 1'b0, 100, 0, 0, 100, "win_roll");
    chk("win.flag", int'(win1), 1);
    chk("win.winner", int'(wnr1), 0);
    // Terminal state ignores further rolls
    @(negedge clk);
    roll1 = 1'b1; dice1 = 3'd1;
    @(negedge clk);
    roll1 = 1'b0;
    chk("over.busy", int'(busy1), 0);
    md_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (md1) md_seen = 1;
    end
    chk("over.no_done", md_seen, 0);
    chk("over.win", int'(win1), 1);
    read_pos(0, 0, p);
    chk("over.pos0", p, 100);

    // Reset abandons a move caught in LOOKUP
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2.win", int'(win1), 0);
    chk("rst2.cur", int'(cur1), 0);
    turn(0, 3'd3, 1'b0, 3, 0, 1, 3, "r2a");
    turn(0, 3'd1, 1'b0, 1, 0, 2, 1, "r2b");
    turn(0, 3'd1, 1'b0, 1, 0, 3, 1, "r2c");
    turn(0, 3'd1, 1'b0, 1, 0, 0, 1, "r2d");
    @(negedge clk);
    roll1 = 1'b1; dice1 = 3'd6;
    @(negedge clk);
    roll1 = 1'b0;
    @(negedge clk);
    chk("abort.query", int'(q1), 9);
    reset = 1'b1;
    @(negedge clk);
    chk("abort.done", int'(md1), 0);
    chk("abort.cur", int'(cur1), 0);
    chk("abort.win", int'(win1), 0);
    read_pos(0, 0, p);
    chk("abort.pos0", p, 0);
    read_pos(0, 1, p);
    chk("abort.pos1", p, 0);
    reset = 1'b0;

    // Two-player instance: wrap from player 1 to 0 and read port beyond NUM_PLAYERS
    @(negedge clk);
    turn(1, 3'd4, 1'b0, 4, 0, 1, 4, "np2.p0");
    turn(1, 3'd2, 1'b0, 2, 0, 0, 2, "np2.p1wrap");
    read_pos(1, 2, p);
    chk("np2.rd2", p, 0);
    read_pos(1, 3, p);
    chk("np2.rd3", p, 0);
    turn(1, 3'd7, 1'b0, 4, 1, 1, 4, "np2.bad");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
